// File: rtl/hdmi_period_sequencer.sv
// Raster timing generator and TMDS period scheduler: walks h/v counters, fetches pixels,
// and picks control / preamble / guard / video symbols for the three channels.
module hdmi_period_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        px_req,
  output logic [15:0] px_x,
  output logic [15:0] px_y,
  input  logic [23:0] px_rgb,
  output logic [23:0] enc_din,
  input  logic [29:0] enc_q,
  output logic [29:0] tmds_sym,
  output logic        de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] PRE_BEG  = 16'(H_TOTAL - 10);
  localparam logic [15:0] GRD_BEG  = 16'(H_TOTAL - 2);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] V_ACT_M1 = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [9:0] CTL_00    = 10'b1101010100;
  localparam logic [9:0] CTL_01    = 10'b0010101011;
  localparam logic [9:0] CTL_10    = 10'b0101010100;
  localparam logic [9:0] CTL_11    = 10'b1010101011;
  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

  typedef enum logic [1:0] {
    CLS_CONTROL  = 2'd0,
    CLS_PREAMBLE = 2'd1,
    CLS_GUARD    = 2'd2,
    CLS_VIDEO    = 2'd3
  } beat_cls_e;

  // Per-beat attributes carried alongside the pixel so every class sees the same latency.
  typedef struct packed {
    beat_cls_e cls;
    logic      hs;
    logic      vs;
  } beat_t;

  function automatic logic [9:0] ctl_sym(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return CTL_00;
      2'b01:   return CTL_01;
      2'b10:   return CTL_10;
      default: return CTL_11;
    endcase
  endfunction

  localparam beat_t       BEAT_IDLE = '{cls: CLS_CONTROL, hs: ~HSYNC_POL, vs: ~VSYNC_POL};
  localparam logic [29:0] RESET_SYM = {CTL_00, CTL_00, ctl_sym(~VSYNC_POL, ~HSYNC_POL)};

  logic [15:0]      h_q, h_d, v_q, v_d;
  beat_t [2:0]      pipe_q, pipe_d;
  logic [23:0]      rgb_q, rgb_d;
  logic [29:0]      tmds_q, tmds_d;
  logic             de_q, de_d;

  logic             active, hs_on, vs_on, next_active;
  beat_t            beat_cur;
  logic [9:0]       ch0_ctl;

  always_comb begin
    h_d = h_q + 16'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 16'd0;
      v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
    end
  end

  always_comb begin
    active      = (h_q < H_ACT) && (v_q < V_ACT);
    hs_on       = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_on       = (v_q >= VS_BEG) && (v_q < VS_END);
    next_active = (v_q == V_LAST) || (v_q < V_ACT_M1);

    beat_cur.hs  = hs_on ? HSYNC_POL : ~HSYNC_POL;
    beat_cur.vs  = vs_on ? VSYNC_POL : ~VSYNC_POL;
    beat_cur.cls = CLS_CONTROL;
    if (active)
      beat_cur.cls = CLS_VIDEO;
    else if (HDMI_MODE && next_active && (h_q >= GRD_BEG))
      beat_cur.cls = CLS_GUARD;
    else if (HDMI_MODE && next_active && (h_q >= PRE_BEG))
      beat_cur.cls = CLS_PREAMBLE;

    px_req = active;
    px_x   = active ? h_q : 16'd0;
    px_y   = active ? v_q : 16'd0;
  end

  // Stage 0 is the beat whose pixel is arriving on px_rgb this cycle.
  always_comb begin
    pipe_d[0] = beat_cur;
    pipe_d[1] = pipe_q[0];
    pipe_d[2] = pipe_q[1];
    rgb_d     = (pipe_q[0].cls == CLS_VIDEO) ? px_rgb : 24'd0;
  end

  always_comb begin
    ch0_ctl = ctl_sym(pipe_q[2].vs, pipe_q[2].hs);
    de_d    = 1'b0;
    case (pipe_q[2].cls)
      CLS_VIDEO: begin
        tmds_d = enc_q;
        de_d   = 1'b1;
      end
      CLS_GUARD:    tmds_d = {GUARD_CH2, GUARD_CH1, GUARD_CH0};
      CLS_PREAMBLE: tmds_d = {CTL_00, CTL_01, ch0_ctl};
      default:      tmds_d = {CTL_00, CTL_00, ch0_ctl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= 16'd0;
      v_q    <= V_ACT;
      pipe_q <= {BEAT_IDLE, BEAT_IDLE, BEAT_IDLE};
      rgb_q  <= 24'd0;
      tmds_q <= RESET_SYM;
      de_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      pipe_q <= pipe_d;
      rgb_q  <= rgb_d;
      tmds_q <= tmds_d;
      de_q   <= de_d;
    end
  end

  assign enc_din  = rgb_q;
  assign tmds_sym = tmds_q;
  assign de       = de_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: default timing, a small HDMI raster with flipped hsync
// polarity and a mid-frame reset, and a small plain-DVI raster, each against a scoreboard.
module tb_hdmi_period_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  int errors = 0;
  int checks = 0;

  localparam int C_HA[3]   = '{640, 8, 8};
  localparam int C_HF[3]   = '{16, 2, 2};
  localparam int C_HS[3]   = '{96, 3, 3};
  localparam int C_HB[3]   = '{48, 10, 10};
  localparam int C_VA[3]   = '{480, 4, 4};
  localparam int C_VF[3]   = '{10, 1, 1};
  localparam int C_VS[3]   = '{2, 2, 2};
  localparam int C_VB[3]   = '{33, 2, 2};
  localparam int C_HP[3]   = '{0, 1, 0};
  localparam int C_VP[3]   = '{0, 0, 1};
  localparam int C_MODE[3] = '{1, 1, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Stand-in for the TMDS encoders: any bijective-looking scramble so a lane swap shows up.
  function automatic logic [29:0] enc_fn(input logic [23:0] d);
    if (d == 24'h123456) return 30'h2AAAAAAA;
    return {d[7:0] ^ d[15:8], d[23:16], d[15:8], ~d[5:0]};
  endfunction

  function automatic logic [31:0] reset_word(input int g);
    logic [1:0] c;
    c = {~1'(C_VP[g]), ~1'(C_HP[g])};
    return {2'b00, 10'b1101010100, 10'b1101010100, ctl_code(c)};
  endfunction

  // Expected {de, tmds_sym} for a non-video beat at raster position (h, v).
  function automatic logic [31:0] blank_word(input int g, input int h, input int v);
    int ht, vt;
    logic hs_lvl, vs_lvl, nxt;
    logic [9:0] c0;
    ht = C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
    vt = C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g];
    hs_lvl = ((h >= C_HA[g] + C_HF[g]) && (h < C_HA[g] + C_HF[g] + C_HS[g])) ? 1'(C_HP[g]) : ~1'(C_HP[g]);
    vs_lvl = ((v >= C_VA[g] + C_VF[g]) && (v < C_VA[g] + C_VF[g] + C_VS[g])) ? 1'(C_VP[g]) : ~1'(C_VP[g]);
    nxt = (v == vt - 1) || (v < C_VA[g] - 1);
    c0 = ctl_code({vs_lvl, hs_lvl});
    if (C_MODE[g] == 1 && nxt && h >= ht - 2)
      return {2'b00, 10'b1011001100, 10'b0100110011, 10'b1011001100};
    if (C_MODE[g] == 1 && nxt && h >= ht - 10)
      return {2'b00, 10'b1101010100, 10'b0010101011, c0};
    return {2'b00, 10'b1101010100, 10'b1101010100, c0};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int HT = C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
    localparam int VT = C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g];

    logic        px_req;
    logic [15:0] px_x, px_y;
    logic [23:0] px_rgb, enc_din;
    logic [29:0] enc_q, tmds_sym;
    logic        de;

    hdmi_period_sequencer #(
      .H_ACTIVE (C_HA[g]), .H_FP(C_HF[g]), .H_SYNC(C_HS[g]), .H_BP(C_HB[g]),
      .V_ACTIVE (C_VA[g]), .V_FP(C_VF[g]), .V_SYNC(C_VS[g]), .V_BP(C_VB[g]),
      .HSYNC_POL(1'(C_HP[g])), .VSYNC_POL(1'(C_VP[g])), .HDMI_MODE(1'(C_MODE[g]))
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .px_req  (px_req),
      .px_x    (px_x),
      .px_y    (px_y),
      .px_rgb  (px_rgb),
      .enc_din (enc_din),
      .enc_q   (enc_q),
      .tmds_sym(tmds_sym),
      .de      (de)
    );

    always @(posedge clk) enc_q <= enc_fn(enc_din);

    logic [31:0] exp_q[$];
    logic [31:0] din_q[$];
    int          mh, mv, since_rst, guard_hits;
    bit          armed, seen, prev_vid, first_px, vid;
    logic [23:0] prev_rgb, rgb;
    logic [31:0] e;
    string       tg;

    initial begin
      tg = $sformatf("cfg%0d", g);
      armed = 1'b0; seen = 1'b0; prev_vid = 1'b0; first_px = 1'b1;
      mh = 0; mv = 0; since_rst = 0; guard_hits = 0;
      prev_rgb = 24'd0; px_rgb = 24'd0;
    end

    always @(negedge clk) begin
      // The pixel for the previous beat is returned now; junk otherwise.
      px_rgb = prev_vid ? prev_rgb : 24'($urandom);
      if (armed) begin
        vid = (mh < C_HA[g]) && (mv < C_VA[g]);
        check_eq({tg, ".px_req"}, 32'(px_req), 32'(vid));
        check_eq({tg, ".px_x"}, 32'(px_x), vid ? mh : 0);
        check_eq({tg, ".px_y"}, 32'(px_y), vid ? mv : 0);
        rgb = 24'd0;
        if (vid) begin
          rgb = (g == 0 && first_px) ? 24'h123456 : 24'($urandom);
          first_px = 1'b0;
        end
        e = vid ? {2'b01, enc_fn(rgb)} : blank_word(g, mh, mv);
        exp_q.push_back(e);
        din_q.push_back({8'd0, rgb});
        check_eq({tg, ".tmds"}, {1'b0, de, tmds_sym}, exp_q.pop_front());
        check_eq({tg, ".enc_din"}, {8'd0, enc_din}, din_q.pop_front());
        if (!seen) begin
          if (px_req) begin
            check_eq({tg, ".first_px_cycles"}, since_rst, (VT - C_VA[g]) * HT);
            seen = 1'b1;
          end else begin
            since_rst++;
          end
        end
        if (!de && (tmds_sym[19:10] == 10'b0010101011 || tmds_sym[19:10] == 10'b0100110011))
          guard_hits++;
        prev_vid = vid;
        prev_rgb = rgb;
      end
      if (rst[g]) begin
        armed = 1'b1;
        mh = 0;
        mv = C_VA[g];
        exp_q.delete();
        din_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(reset_word(g));
        for (int i = 0; i < 2; i++) din_q.push_back(32'd0);
        since_rst = 0;
        seen = 1'b0;
        prev_vid = 1'b0;
      end else if (armed) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  end

  initial begin
    rst = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    // Small HDMI raster: reset during active beat (3,2) of its second frame.
    repeat (371) @(posedge clk);
    #1 rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    // Default raster: vertical blanking, the first two video lines and their blanking.
    repeat (36000 + 1600 + 20 - 372) @(posedge clk);
    check_eq("cfg0.first_px_seen", 32'(gen_cfg[0].seen), 32'd1);
    check_eq("cfg1.first_px_seen", 32'(gen_cfg[1].seen), 32'd1);
    check_eq("cfg2.first_px_seen", 32'(gen_cfg[2].seen), 32'd1);
    check_eq("cfg2.dvi_guard_preamble_hits", gen_cfg[2].guard_hits, 32'd0);
    check_eq("cfg1.hdmi_guard_preamble_seen", 32'(gen_cfg[1].guard_hits > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
